// File: rtl/sj_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sj_regs_pkg
// Purpose : Shared SJA1000 (PeliCAN) register map, command/status bit
//           definitions, receive-sequencer state encoding and small helpers
//           used by the RX frame fetch logic.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package sj_regs_pkg;

    // Register addresses
    localparam logic [7:0] SJ_ADDR_CMR   = 8'd1;
    localparam logic [7:0] SJ_ADDR_SR    = 8'd2;
    localparam logic [7:0] SJ_ADDR_RXBUF = 8'd16;

    // Command register: release receive buffer
    localparam logic [7:0] SJ_CMR_RRB    = 8'h04;
    // Status register: receive buffer status bit
    localparam int         SJ_SR_RBS_BIT = 0;

    // Receive sequencer state encoding
    typedef logic [3:0] sj_state_t;
    localparam sj_state_t S_IDLE      = 4'd0;
    localparam sj_state_t S_SR_REQ    = 4'd1;
    localparam sj_state_t S_SR_WAIT   = 4'd2;
    localparam sj_state_t S_INFO_REQ  = 4'd3;
    localparam sj_state_t S_INFO_WAIT = 4'd4;
    localparam sj_state_t S_BYTE_REQ  = 4'd5;
    localparam sj_state_t S_BYTE_WAIT = 4'd6;
    localparam sj_state_t S_REL_REQ   = 4'd7;
    localparam sj_state_t S_REL_WAIT  = 4'd8;
    localparam sj_state_t S_DONE      = 4'd9;

    // Number of RX-buffer bytes following the frame-info byte:
    // ID bytes (2 or 4) plus data bytes (none for RTR, DLC capped at 8).
    function automatic logic [3:0] sj_rx_nbytes(input logic       ide,
                                                input logic       rtr,
                                                input logic [3:0] dlc);
        logic [3:0] n_data;
        n_data = rtr ? 4'd0 : ((dlc > 4'd8) ? 4'd8 : dlc);
        return (ide ? 4'd4 : 4'd2) + n_data;
    endfunction

    // idb holds the first four ID bytes, first received byte in [31:24].
    function automatic logic [28:0] sj_pack_id(input logic        ide,
                                               input logic [31:0] idb);
        return ide ? idb[31:3] : {18'd0, idb[31:21]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sj_bus_req.sv
`default_nettype none
// ============================================================================
// Module  : sj_bus_req
// Purpose : Request-pulse / wait-for-finish helper shared by the read and
//           write paths of the SJA1000 receive sequencer. Registers the
//           one-cycle read_en/write_en pulse, holds addr/wr_data until the
//           next request, and reports completion (and optionally timeout).
// Ports   : clk, rst_n              - clock, async active-low reset
//           req_rd / req_wr         - issue request next cycle (one-cycle)
//           req_addr / req_wdata    - address / write data of the request
//           in_wait                 - sequencer is waiting for completion
//           read/write_finish_flag  - completion pulses from bus stages
//           read_en / write_en      - request pulses to bus stages
//           addr / wr_data          - held bus address / write data
//           done / timeout          - completion / abort indications
// Config  : SJ_RX_TIMEOUT_EN - enables the TIMEOUT_CYC wait counter
// Revision: 1.0 - initial release
// ============================================================================
module sj_bus_req #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_rd,
    input  logic       req_wr,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic       in_wait,
    input  logic       read_finish_flag,
    input  logic       write_finish_flag,
    output logic       read_en,
    output logic       write_en,
    output logic [7:0] addr,
    output logic [7:0] wr_data,
    output logic       done,
    output logic       timeout
);

    logic       read_en_q,  read_en_d;
    logic       write_en_q, write_en_d;
    logic [7:0] addr_q,     addr_d;
    logic [7:0] wr_data_q,  wr_data_d;
    logic       pend_wr_q,  pend_wr_d;

    always_comb begin
        read_en_d  = req_rd;
        // Read wins if both are ever raised, so the pulses stay exclusive.
        write_en_d = req_wr & ~req_rd;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        pend_wr_d  = pend_wr_q;
        if (req_rd | req_wr) begin
            addr_d    = req_addr;
            wr_data_d = req_wdata;
            pend_wr_d = ~req_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_en_q  <= 1'b0;
            write_en_q <= 1'b0;
            addr_q     <= 8'd0;
            wr_data_q  <= 8'd0;
            pend_wr_q  <= 1'b0;
        end else begin
            read_en_q  <= read_en_d;
            write_en_q <= write_en_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            pend_wr_q  <= pend_wr_d;
        end
    end

    assign read_en  = read_en_q;
    assign write_en = write_en_q;
    assign addr     = addr_q;
    assign wr_data  = wr_data_q;

    // Only the finish flag of the outstanding transaction type counts.
    assign done = in_wait & (pend_wr_q ? write_finish_flag : read_finish_flag);

`ifdef SJ_RX_TIMEOUT_EN
    localparam int             CW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]  c_limit = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = in_wait ? (wait_cnt_q + CW'(1)) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // A finish flag arriving on the limit cycle still counts as success.
    assign timeout = in_wait & ~done & (wait_cnt_q == c_limit);
`else
    assign timeout = 1'b0;

    // No wait counter in this build; TIMEOUT_CYC only needs to be sane.
    if (TIMEOUT_CYC < 1) begin : g_timeout_cfg_invalid
    end
`endif

endmodule
`default_nettype wire

// File: rtl/sj_rx_frame_fetch.sv
`default_nettype none
// ============================================================================
// Module  : sj_rx_frame_fetch
// Purpose : SJA1000 (PeliCAN) receive-frame sequencer. Polls SR, reads the
//           RX buffer window (info + ID + data bytes), releases the buffer
//           via CMR.RRB and presents one assembled frame.
// Ports   : clk, rst_n                    - clock, async active-low reset
//           poll_en                       - polling enable (sampled in idle)
//           read_en, write_en, addr,
//           wr_data                       - parallel-bus request side
//           rd_data, read_finish_flag,
//           write_finish_flag             - parallel-bus completion side
//           frame_valid, frame_ide, frame_rtr, frame_id, frame_dlc,
//           frame_data                    - assembled frame output
//           bus_err                       - timeout abort pulse
// Config  : SJ_RX_TIMEOUT_EN - abort a bus wait after TIMEOUT_CYC cycles
// Revision: 1.0 - initial release
// ============================================================================
module sj_rx_frame_fetch
    import sj_regs_pkg::*;
#(
    parameter int POLL_DIV    = 3000,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        poll_en,
    output logic        read_en,
    output logic        write_en,
    output logic [7:0]  addr,
    output logic [7:0]  wr_data,
    input  logic [7:0]  rd_data,
    input  logic        read_finish_flag,
    input  logic        write_finish_flag,
    output logic        frame_valid,
    output logic        frame_ide,
    output logic        frame_rtr,
    output logic [28:0] frame_id,
    output logic [3:0]  frame_dlc,
    output logic [63:0] frame_data,
    output logic        bus_err
);

    localparam int            PW          = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [PW-1:0] c_poll_last = PW'(POLL_DIV - 1);

    sj_state_t     state_q,       state_d;
    logic [PW-1:0] poll_cnt_q,    poll_cnt_d;
    logic [3:0]    idx_q,         idx_d;
    logic [3:0]    nbytes_q,      nbytes_d;
    logic          ide_q,         ide_d;
    logic          rtr_q,         rtr_d;
    logic [3:0]    dlc_q,         dlc_d;
    logic [95:0]   rx_q,          rx_d;      // byte k of the window at [8k+:8]
    logic          frame_valid_q, frame_valid_d;
    logic          frame_ide_q,   frame_ide_d;
    logic          frame_rtr_q,   frame_rtr_d;
    logic [28:0]   frame_id_q,    frame_id_d;
    logic [3:0]    frame_dlc_q,   frame_dlc_d;
    logic [63:0]   frame_data_q,  frame_data_d;
    logic          bus_err_q,     bus_err_d;

    logic          req_rd, req_wr, in_wait, done, timeout;
    logic [7:0]    req_addr, req_wdata;

    always_comb begin
        state_d       = state_q;
        poll_cnt_d    = poll_cnt_q;
        idx_d         = idx_q;
        nbytes_d      = nbytes_q;
        ide_d         = ide_q;
        rtr_d         = rtr_q;
        dlc_d         = dlc_q;
        rx_d          = rx_q;
        frame_valid_d = 1'b0;
        frame_ide_d   = frame_ide_q;
        frame_rtr_d   = frame_rtr_q;
        frame_id_d    = frame_id_q;
        frame_dlc_d   = frame_dlc_q;
        frame_data_d  = frame_data_q;
        bus_err_d     = timeout;

        case (state_q)
            S_IDLE: begin
                if (!poll_en) begin
                    poll_cnt_d = '0;
                end else if (poll_cnt_q == c_poll_last) begin
                    poll_cnt_d = '0;
                    state_d    = S_SR_REQ;
                end else begin
                    poll_cnt_d = poll_cnt_q + PW'(1);
                end
            end
            S_SR_REQ:   state_d = S_SR_WAIT;
            S_SR_WAIT: begin
                if (done) begin
                    state_d = rd_data[SJ_SR_RBS_BIT] ? S_INFO_REQ : S_IDLE;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_INFO_REQ: state_d = S_INFO_WAIT;
            S_INFO_WAIT: begin
                if (done) begin
                    ide_d    = rd_data[7];
                    rtr_d    = rd_data[6];
                    dlc_d    = rd_data[3:0];
                    nbytes_d = sj_rx_nbytes(rd_data[7], rd_data[6], rd_data[3:0]);
                    rx_d     = '0;
                    idx_d    = '0;
                    state_d  = S_BYTE_REQ;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_BYTE_REQ: state_d = S_BYTE_WAIT;
            S_BYTE_WAIT: begin
                if (done) begin
                    for (int i = 0; i < 12; i++) begin
                        if (idx_q == 4'(i)) begin
                            rx_d[i*8 +: 8] = rd_data;
                        end
                    end
                    idx_d   = idx_q + 4'd1;
                    state_d = (idx_q + 4'd1 == nbytes_q) ? S_REL_REQ : S_BYTE_REQ;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_REL_REQ:  state_d = S_REL_WAIT;
            S_REL_WAIT: begin
                if (done) begin
                    frame_valid_d = 1'b1;
                    frame_ide_d   = ide_q;
                    frame_rtr_d   = rtr_q;
                    frame_dlc_d   = dlc_q;
                    frame_id_d    = sj_pack_id(ide_q, {rx_q[7:0], rx_q[15:8],
                                                       rx_q[23:16], rx_q[31:24]});
                    // Unread bytes were cleared at the info stage, so the
                    // window slice is already zero-padded.
                    frame_data_d  = ide_q ? rx_q[95:32] : rx_q[79:16];
                    state_d       = S_DONE;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        // Request pulses are registered in sj_bus_req, so they are raised
        // from the next state and appear exactly while in a *_REQ state.
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 8'd0;
        req_wdata = 8'd0;
        case (state_d)
            S_SR_REQ: begin
                req_rd   = 1'b1;
                req_addr = SJ_ADDR_SR;
            end
            S_INFO_REQ: begin
                req_rd   = 1'b1;
                req_addr = SJ_ADDR_RXBUF;
            end
            S_BYTE_REQ: begin
                req_rd   = 1'b1;
                req_addr = SJ_ADDR_RXBUF + 8'd1 + {4'd0, idx_d};
            end
            S_REL_REQ: begin
                req_wr    = 1'b1;
                req_addr  = SJ_ADDR_CMR;
                req_wdata = SJ_CMR_RRB;
            end
            default: ;
        endcase

        in_wait = (state_q == S_SR_WAIT)   || (state_q == S_INFO_WAIT) ||
                  (state_q == S_BYTE_WAIT) || (state_q == S_REL_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            poll_cnt_q    <= '0;
            idx_q         <= '0;
            nbytes_q      <= '0;
            ide_q         <= 1'b0;
            rtr_q         <= 1'b0;
            dlc_q         <= '0;
            rx_q          <= '0;
            frame_valid_q <= 1'b0;
            frame_ide_q   <= 1'b0;
            frame_rtr_q   <= 1'b0;
            frame_id_q    <= '0;
            frame_dlc_q   <= '0;
            frame_data_q  <= '0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            poll_cnt_q    <= poll_cnt_d;
            idx_q         <= idx_d;
            nbytes_q      <= nbytes_d;
            ide_q         <= ide_d;
            rtr_q         <= rtr_d;
            dlc_q         <= dlc_d;
            rx_q          <= rx_d;
            frame_valid_q <= frame_valid_d;
            frame_ide_q   <= frame_ide_d;
            frame_rtr_q   <= frame_rtr_d;
            frame_id_q    <= frame_id_d;
            frame_dlc_q   <= frame_dlc_d;
            frame_data_q  <= frame_data_d;
            bus_err_q     <= bus_err_d;
        end
    end

    sj_bus_req #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_bus_req (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_rd            (req_rd),
        .req_wr            (req_wr),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .in_wait           (in_wait),
        .read_finish_flag  (read_finish_flag),
        .write_finish_flag (write_finish_flag),
        .read_en           (read_en),
        .write_en          (write_en),
        .addr              (addr),
        .wr_data           (wr_data),
        .done              (done),
        .timeout           (timeout)
    );

    assign frame_valid = frame_valid_q;
    assign frame_ide   = frame_ide_q;
    assign frame_rtr   = frame_rtr_q;
    assign frame_id    = frame_id_q;
    assign frame_dlc   = frame_dlc_q;
    assign frame_data  = frame_data_q;
    assign bus_err     = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sj_rx_frame_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_sj_rx_frame_fetch
// Purpose : Self-checking bench for sj_rx_frame_fetch. A bus responder
//           backed by a register-file array answers reads/writes with a
//           fixed latency; a behavioural frame model predicts each frame.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sj_rx_frame_fetch;

    localparam int POLL_DIV    = 40;
    localparam int TIMEOUT_CYC = 64;
    localparam int LAT         = 11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        poll_en;
    logic        read_en, write_en;
    logic [7:0]  addr, wr_data;
    logic [7:0]  rd_data;
    logic        read_finish_flag, write_finish_flag;
    logic        frame_valid, frame_ide, frame_rtr;
    logic [28:0] frame_id;
    logic [3:0]  frame_dlc;
    logic [63:0] frame_data;
    logic        bus_err;

    sj_rx_frame_fetch #(
        .POLL_DIV    (POLL_DIV),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .poll_en           (poll_en),
        .read_en           (read_en),
        .write_en          (write_en),
        .addr              (addr),
        .wr_data           (wr_data),
        .rd_data           (rd_data),
        .read_finish_flag  (read_finish_flag),
        .write_finish_flag (write_finish_flag),
        .frame_valid       (frame_valid),
        .frame_ide         (frame_ide),
        .frame_rtr         (frame_rtr),
        .frame_id          (frame_id),
        .frame_dlc         (frame_dlc),
        .frame_data        (frame_data),
        .bus_err           (bus_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [7:0]  mem [0:255];
    logic [7:0]  fb  [0:11];

    // Bus responder / monitor state
    int          cyc = 0;
    int          rd_cnt = 0, wr_cnt = 0;
    logic [7:0]  rd_addr, wr_addr, wr_val;
    int          reads_seen = 0, writes_seen = 0, frames = 0, errs = 0, both_hi = 0;
    int          last_rd_cyc = 0, last_rdfin_cyc = 0, last_wrfin_cyc = 0;
    int          frame_cyc = 0, err_cyc = 0;
    logic [7:0]  last_rd_addr = 8'd0, last_wr_addr = 8'd0, last_wr_data = 8'd0;
    logic        hold_info = 1'b0;
    logic        got_ide, got_rtr;
    logic [28:0] got_id;
    logic [3:0]  got_dlc;
    logic [63:0] got_data;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Frame model straight from the RX buffer layout rules.
    function automatic void model(input logic [7:0] info, output logic [28:0] eid,
                                  output logic [63:0] edata, output int n);
        int nid, nd;
        longint id;
        nid = info[7] ? 4 : 2;
        nd  = info[6] ? 0 : ((int'(info[3:0]) > 8) ? 8 : int'(info[3:0]));
        if (info[7])
            id = longint'(fb[0]) * 2097152 + longint'(fb[1]) * 8192 +
                 longint'(fb[2]) * 32 + longint'(fb[3]) / 8;
        else
            id = longint'(fb[0]) * 8 + longint'(fb[1]) / 32;
        eid   = 29'(id);
        edata = '0;
        for (int i = 0; i < nd; i++) edata = edata | (64'(fb[nid + i]) << (8 * i));
        n = nid + nd;
    endfunction

    // Bus responder and monitor: acts on the negative edge.
    initial begin
        read_finish_flag  = 1'b0;
        write_finish_flag = 1'b0;
        rd_data           = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            read_finish_flag  = 1'b0;
            write_finish_flag = 1'b0;
            rd_data           = 8'($urandom);
            if (!rst_n) begin
                rd_cnt = 0;
                wr_cnt = 0;
            end else begin
                if (read_en && write_en) both_hi++;
                if (rd_cnt > 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0 && !(hold_info && rd_addr == 8'd16)) begin
                        read_finish_flag = 1'b1;
                        rd_data          = mem[rd_addr];
                        last_rdfin_cyc   = cyc;
                    end
                end
                if (wr_cnt > 0) begin
                    wr_cnt--;
                    if (wr_cnt == 0) begin
                        write_finish_flag = 1'b1;
                        last_wrfin_cyc    = cyc;
                        if (wr_addr == 8'd1 && wr_val[2]) mem[2] = 8'h00;
                    end
                end
                if (read_en) begin
                    rd_cnt = LAT; rd_addr = addr; reads_seen++;
                    last_rd_cyc = cyc; last_rd_addr = addr;
                end
                if (write_en) begin
                    wr_cnt = LAT; wr_addr = addr; wr_val = wr_data; writes_seen++;
                    last_wr_addr = addr; last_wr_data = wr_data;
                end
                if (frame_valid) begin
                    frames++; frame_cyc = cyc;
                    got_ide = frame_ide; got_rtr = frame_rtr; got_id = frame_id;
                    got_dlc = frame_dlc; got_data = frame_data;
                end
                if (bus_err) begin
                    errs++; err_cyc = cyc;
                end
            end
        end
    end

    task automatic load_frame(input logic [7:0] info);
        mem[16] = info;
        for (int i = 0; i < 12; i++) mem[17 + i] = fb[i];
        mem[2] = 8'h01;
    endtask

    task automatic check_frame(input logic [7:0] info);
        logic [28:0] eid;
        logic [63:0] edata;
        int          n;
        model(info, eid, edata, n);
        check_eq("frame_ide",  64'(got_ide),  64'(info[7]));
        check_eq("frame_rtr",  64'(got_rtr),  64'(info[6]));
        check_eq("frame_dlc",  64'(got_dlc),  64'(info[3:0]));
        check_eq("frame_id",   64'(got_id),   64'(eid));
        check_eq("frame_data", got_data,      edata);
    endtask

    task automatic run_frame(input logic [7:0] info);
        int r0, w0, f0, n;
        logic [28:0] eid;
        logic [63:0] edata;
        load_frame(info);
        r0 = reads_seen; w0 = writes_seen; f0 = frames;
        poll_en = 1'b1;
        for (int k = 0; k < 3000 && frames == f0; k++) tick();
        poll_en = 1'b0;
        check_eq("frame_seen", 64'(frames - f0), 64'd1);
        check_frame(info);
        model(info, eid, edata, n);
        check_eq("read_count",   64'(reads_seen - r0), 64'(2 + n));
        check_eq("write_count",  64'(writes_seen - w0), 64'd1);
        check_eq("rel_addr",     64'(last_wr_addr), 64'd1);
        check_eq("rel_data",     64'(last_wr_data), 64'h04);
        check_eq("valid_lat",    64'(frame_cyc - last_wrfin_cyc), 64'd1);
        check_eq("buf_released", 64'(mem[2]), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_read_en"},  64'(read_en),     64'd0);
        check_eq({tag, "_write_en"}, 64'(write_en),    64'd0);
        check_eq({tag, "_addr"},     64'(addr),        64'd0);
        check_eq({tag, "_wr_data"},  64'(wr_data),     64'd0);
        check_eq({tag, "_valid"},    64'(frame_valid), 64'd0);
        check_eq({tag, "_ide_rtr"},  64'({frame_ide, frame_rtr}), 64'd0);
        check_eq({tag, "_id"},       64'(frame_id),    64'd0);
        check_eq({tag, "_dlc"},      64'(frame_dlc),   64'd0);
        check_eq({tag, "_data"},     frame_data,       64'd0);
        check_eq({tag, "_bus_err"},  64'(bus_err),     64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0, f0, gap;
        logic [7:0] info;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_n   = 1'b0;
        poll_en = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // Standard 8-byte data frame
        fb[0] = 8'h24; fb[1] = 8'h60;
        for (int i = 0; i < 8; i++) fb[2 + i] = 8'h11 + 8'(i);
        fb[10] = 8'hAA; fb[11] = 8'h55;
        run_frame(8'h08);
        check_eq("std_id_const",   64'(got_id),   64'h123);
        check_eq("std_data_const", got_data,      64'h1817161514131211);

        // Extended remote frame
        fb[0] = 8'h12; fb[1] = 8'h34; fb[2] = 8'h56; fb[3] = 8'h78;
        for (int i = 4; i < 12; i++) fb[i] = 8'($urandom);
        run_frame(8'hC3);
        check_eq("ext_id_const", 64'(got_id), 64'h02468ACF);

        // DLC above 8
        for (int i = 0; i < 12; i++) fb[i] = 8'($urandom);
        run_frame(8'h0F);

        // Empty buffer: one SR read per poll, IDLE dwell of POLL_DIV cycles
        mem[2] = 8'h0C;
        r0 = reads_seen; w0 = writes_seen; f0 = frames;
        poll_en = 1'b1;
        for (int k = 0; k < 500 && reads_seen < r0 + 2; k++) tick();
        gap = last_rd_cyc - last_rdfin_cyc;
        poll_en = 1'b0;
        check_eq("empty_reads", 64'(reads_seen - r0), 64'd2);
        check_eq("empty_addr",  64'(last_rd_addr), 64'd2);
        check_eq("poll_gap",    64'(gap), 64'(POLL_DIV + 1));
        repeat (LAT + 4) tick();
        check_eq("empty_no_more_reads", 64'(reads_seen - r0), 64'd2);
        check_eq("empty_no_write",      64'(writes_seen - w0), 64'd0);
        check_eq("empty_no_frame",      64'(frames - f0), 64'd0);

        // Randomized frames
        for (int t = 0; t < 16; t++) begin
            info = 8'($urandom);
            for (int i = 0; i < 12; i++) fb[i] = 8'($urandom);
            run_frame(info);
        end

        // Reset in the middle of the byte reads
        fb[0] = 8'h24; fb[1] = 8'h60;
        for (int i = 2; i < 12; i++) fb[i] = 8'($urandom);
        info = 8'h08;
        load_frame(info);
        last_rd_addr = 8'd0;
        w0 = writes_seen;
        poll_en = 1'b1;
        for (int k = 0; k < 1000 && last_rd_addr != 8'd19; k++) tick();
        check_eq("mid_reached", 64'(last_rd_addr), 64'd19);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) tick();
        check_eq("midrst_no_write", 64'(writes_seen - w0), 64'd0);
        check_eq("midrst_kept_buf", 64'(mem[2][0]), 64'd1);
        rst_n = 1'b1;
        f0 = frames;
        for (int k = 0; k < 3000 && frames == f0; k++) tick();
        poll_en = 1'b0;
        check_eq("refetch_seen", 64'(frames - f0), 64'd1);
        check_frame(info);

`ifdef SJ_RX_TIMEOUT_EN
        // Withheld info-read finish: abort, no release, then recover
        for (int i = 0; i < 12; i++) fb[i] = 8'($urandom);
        info = 8'($urandom);
        load_frame(info);
        hold_info = 1'b1;
        r0 = errs; w0 = writes_seen; f0 = frames;
        poll_en = 1'b1;
        for (int k = 0; k < 1000 && errs == r0; k++) tick();
        poll_en = 1'b0;
        check_eq("to_bus_err",  64'(errs - r0), 64'd1);
        check_eq("to_latency",  64'(err_cyc - last_rd_cyc), 64'(TIMEOUT_CYC + 1));
        check_eq("to_addr",     64'(last_rd_addr), 64'd16);
        check_eq("to_no_write", 64'(writes_seen - w0), 64'd0);
        check_eq("to_no_frame", 64'(frames - f0), 64'd0);
        hold_info = 1'b0;
        repeat (2) tick();
        run_frame(info);
`endif

        check_eq("never_both_req", 64'(both_hi), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sj_rx_frame_fetch.md
# sj_rx_frame_fetch

Receive-frame sequencer for the SJA1000 CAN controller (PeliCAN mode). It sits directly upstream of the parallel-bus read stage and the matching write stage. It polls the status register and, when a frame is buffered, reads the 13-byte RX buffer window byte by byte. It then releases the buffer and presents one assembled frame to the flywheel-control logic. The design runs on a 30 MHz clock (33.33 ns).

## Interface
Parameters:
- POLL_DIV, 3000: clk cycles between status polls (100 µs).
- TIMEOUT_CYC, 64: maximum wait for a bus-stage finish flag (only with timeout compiled in).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- poll_en  in  1  1 = polling enabled; sampled only in S_IDLE.
- read_en  out  1  one-cycle read request pulse to the read stage.
- write_en  out  1  one-cycle write request pulse to the write stage.
- addr  out  8  SJA1000 register address; held stable from the request pulse until the finish flag.
- wr_data  out  8  write data; held with addr.
- rd_data  in  8  read-stage data; valid in the cycle read_finish_flag=1.
- read_finish_flag  in  1  one-cycle read-done pulse.
- write_finish_flag  in  1  one-cycle write-done pulse.
- frame_valid  out  1  one-cycle pulse; frame outputs valid and held until the next pulse.
- frame_ide  out  1  1 = extended (29-bit) ID.
- frame_rtr  out  1  remote frame.
- frame_id  out  29  identifier; a standard ID occupies [10:0] and [28:11] is 0.
- frame_dlc  out  4  raw DLC from the frame-info byte.
- frame_data  out  64  byte 0 in [7:0]; bytes beyond the count read are 0.
- bus_err  out  1  one-cycle pulse on timeout abort.

## Operation
- Reset values:
  - read_en=0, write_en=0, frame_valid=0, bus_err=0.
  - addr=0, wr_data=0.
  - All frame_* outputs are 0.
  - State is S_IDLE and the poll counter is 0.
- Request rules:
  - read_en and write_en are never high together.
  - A request pulse is issued only while no transaction is outstanding, and never in the same cycle a finish flag is seen.
  - This guarantees the downstream level-sampling stages are back in idle.
- S_IDLE: the poll counter counts while poll_en=1 and resets to 0 while poll_en=0. At POLL_DIV-1 it goes to S_SR_REQ.
- S_SR_REQ: addr=2 (SR) and read_en pulses, then go to S_SR_WAIT.
  - On the finish flag, if rd_data[0] (RBS) is 1, go to S_INFO_REQ; otherwise go to S_IDLE.
- S_INFO_REQ / S_INFO_WAIT: read addr=16.
  - Latch ide=bit7, rtr=bit6, dlc=bits[3:0].
  - Compute n = (ide ? 4 : 2) + (rtr ? 0 : min(dlc,8)), giving a range of 2..12.
  - Clear the data accumulator. Set idx=0.
- S_BYTE_REQ / S_BYTE_WAIT: read addr=17+idx and store the byte, then idx++.
  - If idx==n after the increment, go to S_REL_REQ; otherwise go back to S_BYTE_REQ.
- ID packing:
  - Standard: id[10:3]=b17, id[2:0]=b18[7:5].
  - Extended: id[28:21]=b17, id[20:13]=b18, id[12:5]=b19, id[4:0]=b20[7:3].
  - Data bytes follow the ID bytes.
- S_REL_REQ / S_REL_WAIT: write addr=1 (CMR), wr_data=8'h04 (RRB), write_en pulse.
  - On write_finish_flag, go to S_DONE.
- S_DONE: the frame_* outputs update, frame_valid=1 for one cycle, then go to S_IDLE with the poll counter at 0.
- DLC>8 is legal: frame_dlc reports the raw value and 8 data bytes are read.
- Reset mid-frame: everything returns to reset values, no frame_valid is issued, and the RX buffer is not released. The next poll re-reads the frame.

## Timing
- Each state pair REQ→WAIT costs one request cycle plus the read-stage latency; finish arrives 11 cycles after the read_en pulse.
- The next request goes out the cycle after the finish flag is sampled.
- Status poll to frame_valid:
  - Standard 8-byte data frame: 11 reads + 1 write.
  - That is about 12×12 cycles plus write latency, plus 1 cycle in S_DONE.
- frame_valid fires exactly one cycle after write_finish_flag is sampled.

## Configuration
- SJ_RX_TIMEOUT_EN defined: each WAIT state runs a counter.
  - If it reaches TIMEOUT_CYC without a finish flag: bus_err pulses, the partial frame is discarded, the state goes to S_IDLE, and the buffer is not released.
  - A finish flag in the same cycle the limit is reached counts as success.
- SJ_RX_TIMEOUT_EN undefined: WAIT states wait indefinitely, bus_err is tied to 0, and the TIMEOUT_CYC parameter is unused.

## Structure
- Shared package sj_regs_pkg holds:
  - Register addresses SJ_ADDR_CMR=1, SJ_ADDR_SR=2, SJ_ADDR_RXBUF=16.
  - SJ_CMR_RRB=8'h04 and SJ_SR_RBS_BIT=0.
  - The state enum.
- One sub-module, sj_bus_req, holds the request-pulse / wait-finish / timeout logic and is shared by the read and write paths.

## Test plan
- Standard data frame: SR=0x01; info=0x08; bytes 0x24,0x60,11..18.
  - Expect frame_valid with ide=0, rtr=0, id=0x123, dlc=8, data=0x1817161514131211.
  - Expect a write to addr 1 with data 0x04 before frame_valid.
- Extended RTR frame: info=0xC3; ID bytes 0x12,0x34,0x56,0x78.
  - Expect id=0x02468ACF, rtr=1, dlc=3, only 5 reads total after SR, data=0.
- SR=0x00: exactly one read at addr 2, no further requests, and the next poll comes POLL_DIV cycles later.
- info=0x0F (DLC=15): expect 8 data reads and frame_dlc=15.
- Read finish withheld with SJ_RX_TIMEOUT_EN defined: expect bus_err after 64 cycles, no write, and a return to polling.
- rst_n asserted mid-byte-read: all outputs at reset values immediately, and the frame is refetched on the next poll.
